// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port datapath: port geometry, header length field
// location and the packet FSM encoding.
package switch_pkg;

    localparam int SW_N_IN = 4;
    localparam int SW_W    = 32;

    // Header layout: [31:24] dest, [23:8] pkt_length, [7:0] seq
    localparam int HDR_LEN_LSB = 8;
    localparam int HDR_LEN_W   = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    typedef logic [HDR_LEN_W-1:0] pkt_len_t;

    // A zero length would never terminate, so it is read as a header-only packet.
    function automatic pkt_len_t hdr_len(input pkt_len_t raw);
        return (raw == '0) ? pkt_len_t'(1) : raw;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: first asserted request at or after ptr, scanning cyclically.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        // Scan farthest-first so the nearest request to ptr is the last assignment and wins.
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Packet-granular round-robin arbiter for one switch output port: grants one input FIFO per
// packet and streams it, header first, to the registered output link.
module output_port_arbiter
    import switch_pkg::*;
#(
    parameter int N_IN    = SW_N_IN,
    parameter int W       = SW_W,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       fifo_empty,
    input  logic [N_IN*(W+1)-1:0] fifo_data,
    output logic [N_IN-1:0]       fifo_rd_en,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [1:0]            out_src,
    output logic                  abort_pulse,
    output logic                  drop_pulse
);

    localparam int               TO_W    = 16;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]      state;
    logic [1:0]      rr_ptr;
    logic [1:0]      grant;
    pkt_len_t        cnt;
    logic [TO_W-1:0] idle_cnt;

    logic [W:0]      heads [N_IN];
    logic            pick_vld;
    logic [1:0]      pick_idx;
    logic            busy;
    logic            adv;
    logic            gnt_empty;
    logic            pop;
    logic            drop;
    logic            timeout_hit;
    pkt_len_t        len_v;
    logic            last;
    logic [N_IN-1:0] rd_en_c;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            heads[i] = fifo_data[i*(W+1) +: (W+1)];
        end
    end

    rr_pick4 u_pick (
        .req   (~fifo_empty),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign busy      = (state == ST_HDR) || (state == ST_BODY);
    assign adv       = !out_valid || out_ready;
    assign gnt_empty = fifo_empty[grant];
    assign pop       = busy && adv && !gnt_empty;
    assign drop      = (state == ST_IDLE) && pick_vld && !heads[pick_idx][W];
    assign len_v     = hdr_len(heads[grant][HDR_LEN_LSB +: HDR_LEN_W]);
    assign last      = (state == ST_HDR) ? (len_v == pkt_len_t'(1)) : (cnt == pkt_len_t'(1));

    // An empty granted FIFO only counts toward abort while a packet is open.
    assign timeout_hit = (TIMEOUT > 0) && busy && gnt_empty && (idle_cnt == TO_LAST);

    always_comb begin
        rd_en_c = '0;
        if (drop) begin
            rd_en_c[pick_idx] = 1'b1;
        end else if (pop) begin
            rd_en_c[grant] = 1'b1;
        end
    end

    // Pop strobes are combinational; hold them off while reset is asserted.
    assign fifo_rd_en  = rd_en_c & {N_IN{rst_n}};
    assign drop_pulse  = drop & rst_n;
    assign abort_pulse = timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= 2'd0;
            grant  <= 2'd0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld && heads[pick_idx][W]) begin
                        grant <= pick_idx;
                        state <= ST_HDR;
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (pop) begin
                        cnt <= (state == ST_HDR) ? (len_v - pkt_len_t'(1)) : (cnt - pkt_len_t'(1));
                        if (last) begin
                            state  <= ST_IDLE;
                            rr_ptr <= grant + 2'd1;
                        end else begin
                            state <= ST_BODY;
                        end
                    end else if (timeout_hit) begin
                        state  <= ST_IDLE;
                        rr_ptr <= grant + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!busy || pop) begin
            idle_cnt <= '0;
        end else if (gnt_empty && (TIMEOUT > 0)) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    // Output register: a pop always lands here; otherwise a handshake empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_src   <= 2'd0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= heads[grant][W-1:0];
            out_sop   <= (state == ST_HDR);
            out_eop   <= last;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end
    end

endmodule
